// File: rtl/spi_pkg.sv
// Shared definitions for the probe command link SPI responder: frame layout,
// command codes and the receive FSM state type.
package spi_pkg;
  localparam int FRAME_W  = 32;
  localparam int CODE_W   = 6;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int CODE_LSB = 26;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;

  localparam logic [CODE_W-1:0] CMD_NOP       = 6'd0;
  localparam logic [CODE_W-1:0] CMD_WR_REC    = 6'd4;
  localparam logic [CODE_W-1:0] CMD_AFE_RST   = 6'd7;
  localparam logic [CODE_W-1:0] CMD_AFE_UNRST = 6'd8;
  localparam logic [CODE_W-1:0] CMD_WR_ELEC   = 6'd10;
  localparam logic [CODE_W-1:0] CMD_RD_ELEC   = 6'd11;
  localparam logic [CODE_W-1:0] CMD_RD_ADC    = 6'd19;
  localparam logic [CODE_W-1:0] CMD_WR_CHEM   = 6'd20;
  localparam logic [CODE_W-1:0] CMD_RD_CHEM   = 6'd21;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} spi_state_e;
endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the command/response side of the responder, bundled for the
// dispatcher (master modport drives the pins and tx_word).
interface spi_slave_rx_if;
  import spi_pkg::*;
  logic               sck;
  logic               cs_n;
  logic               mosi;
  logic               miso;
  logic [FRAME_W-1:0] tx_word;
  logic               tx_ack;
  logic               cmd_valid;
  logic [CODE_W-1:0]  cmd_code;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_data;
  logic               frame_err;

  modport slave (
    input  sck, cs_n, mosi, tx_word,
    output miso, tx_ack, cmd_valid, cmd_code, cmd_addr, cmd_data, frame_err
  );
  modport master (
    output sck, cs_n, mosi, tx_word,
    input  miso, tx_ack, cmd_valid, cmd_code, cmd_addr, cmd_data, frame_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin plus a third flop for
// rise/fall detection against the synchronized value.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign dout = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_slave_rx.sv
// Oversampling SPI responder: receives 32-bit LSB-first command frames and
// shifts a response word out on miso within the same frame.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int LEN_SPI      = FRAME_W,
  parameter int SPI_CODE_LEN = CODE_W,
  parameter int SPI_ADDR_LEN = ADDR_W,
  parameter int SPI_DATA_LEN = DATA_W
) (
  input logic           clk_50M,
  input logic           rst,
  spi_slave_rx_if.slave bus
);
  localparam int CNT_W = $clog2(LEN_SPI + 2);

  logic sck_s, sck_rise_unused, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // cs_n chain resets low so a select still held across reset is not seen as a new frame
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sck (
    .clk(clk_50M), .rst(rst), .din(bus.sck),
    .dout(sck_s), .rise(sck_rise_unused), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
    .clk(clk_50M), .rst(rst), .din(bus.cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_50M), .rst(rst), .din(bus.mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  spi_state_e              state, state_n;
  logic [LEN_SPI-1:0]      shift_rx, shift_rx_n, shift_tx, shift_tx_n;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_n;
  logic                    pend, pend_n;
  logic                    tx_ack_q, tx_ack_n, valid_q, valid_n, err_q, err_n;
  logic [SPI_CODE_LEN-1:0] code_q, code_n;
  logic [SPI_ADDR_LEN-1:0] addr_q, addr_n;
  logic [SPI_DATA_LEN-1:0] data_q, data_n;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift_rx <= '0;
      shift_tx <= '0;
      bit_cnt  <= '0;
      pend     <= 1'b0;
      tx_ack_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_n;
      shift_rx <= shift_rx_n;
      shift_tx <= shift_tx_n;
      bit_cnt  <= bit_cnt_n;
      pend     <= pend_n;
      tx_ack_q <= tx_ack_n;
      valid_q  <= valid_n;
      err_q    <= err_n;
      code_q   <= code_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_rx_n = shift_rx;
    shift_tx_n = shift_tx;
    bit_cnt_n  = bit_cnt;
    pend_n     = pend;
    tx_ack_n   = 1'b0;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    code_n     = code_q;
    addr_n     = addr_q;
    data_n     = data_q;
    case (state)
      ST_IDLE: begin
        if (cs_fall || pend) begin
          shift_tx_n = bus.tx_word;
          shift_rx_n = '0;
          bit_cnt_n  = '0;
          tx_ack_n   = 1'b1;
          pend_n     = 1'b0;
          state_n    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_n = ST_DONE;
        end else if (sck_fall && !cs_s) begin
          shift_rx_n = {mosi_s, shift_rx[LEN_SPI-1:1]};
          shift_tx_n = shift_tx >> 1;
          if (bit_cnt != CNT_W'(LEN_SPI + 1)) bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        // a select arriving during the decode cycle starts the next frame from IDLE
        pend_n  = cs_fall;
        if (bit_cnt == CNT_W'(LEN_SPI)) begin
          if (shift_rx[LEN_SPI-1 -: SPI_CODE_LEN] != '0) begin
            code_n  = shift_rx[LEN_SPI-1 -: SPI_CODE_LEN];
            addr_n  = shift_rx[SPI_DATA_LEN +: SPI_ADDR_LEN];
            data_n  = shift_rx[SPI_DATA_LEN-1:0];
            valid_n = 1'b1;
          end
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.miso      = (state == ST_SHIFT) && shift_tx[0];
  assign bus.tx_ack    = tx_ack_q;
  assign bus.cmd_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.cmd_code  = code_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_data  = data_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a 5 MHz SPI master model with a scoreboard
// of expected commands checked whenever cmd_valid fires.
module tb_spi_slave_rx;
  import spi_pkg::*;

  typedef struct packed {
    logic [5:0]  code;
    logic [9:0]  addr;
    logic [15:0] data;
  } cmd_t;

  logic clk_50M = 1'b0;
  logic rst;
  spi_slave_rx_if bus ();

  spi_slave_rx dut (.clk_50M(clk_50M), .rst(rst), .bus(bus));

  always #10 clk_50M = ~clk_50M;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int checks = 0, errors = 0;
  int n_err_obs = 0, n_ack_obs = 0, n_err_exp = 0, n_ack_exp = 0;
  logic [31:0] rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_50M) begin
    if (!rst) begin
      if (bus.cmd_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_fields", {bus.cmd_code, bus.cmd_addr, bus.cmd_data}, mon_e);
        end
        chk("valid_err_exclusive", {31'd0, bus.frame_err}, 32'd0);
      end
      if (bus.frame_err) n_err_obs++;
      if (bus.tx_ack) n_ack_obs++;
    end
  end

  // master: mosi changes on sck rise, miso is sampled at sck fall
  task automatic send(input logic [31:0] word, input int nbits, input logic [31:0] txw,
                      output logic [31:0] rxd);
    if (nbits == 32 && word[31:26] != 6'd0) exp_q.push_back(cmd_t'(word));
    if (nbits != 32) n_err_exp++;
    n_ack_exp++;
    rxd = '0;
    bus.tx_word = txw;
    bus.mosi = word[0];
    bus.cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      if (i < 32) rxd[i] = bus.miso;
      bus.sck = 1'b0;
      #100;
      bus.sck = 1'b1;
      bus.mosi = (i + 1 < 32) ? word[i + 1] : 1'b0;
      #100;
    end
    bus.cs_n = 1'b1;
    #100;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_miso"},  {31'd0, bus.miso}, 32'd0);
    chk({tag, "_ack"},   {31'd0, bus.tx_ack}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.cmd_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_fields"}, {bus.cmd_code, bus.cmd_addr, bus.cmd_data}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cs_n = 1'b1;
    bus.sck = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_word = '0;
    #25;
    chk_zero_outputs("reset");
    #80;
    rst = 1'b0;
    #200;

    // basic write-record command
    send({6'd4, 10'h008, 16'h001D}, 32, 32'h0, rx);
    #200;
    chk("wr_rec_code", {26'd0, bus.cmd_code}, 32'd4);
    chk("wr_rec_addr", {22'd0, bus.cmd_addr}, 32'h008);
    chk("wr_rec_data", {16'd0, bus.cmd_data}, 32'h001D);
    chk("wr_rec_miso", rx, 32'h0);

    // response word shifted out during an ADC read
    send({6'd19, 10'h00B, 16'h0}, 32, 32'hA5A5_3C01, rx);
    #200;
    chk("rd_adc_miso", rx, 32'hA5A5_3C01);
    chk("rd_adc_code", {26'd0, bus.cmd_code}, 32'd19);
    chk("rd_adc_addr", {22'd0, bus.cmd_addr}, 32'h00B);
    chk("ack_count_2", n_ack_obs, n_ack_exp);

    // NOP frame leaves fields untouched
    send(32'h0, 32, 32'h1234_5678, rx);
    #200;
    chk("nop_fields", {bus.cmd_code, bus.cmd_addr, bus.cmd_data}, {6'd19, 10'h00B, 16'h0});
    chk("nop_err", n_err_obs, n_err_exp);
    chk("nop_miso", rx, 32'h1234_5678);

    // short and long frames
    send({6'd10, 10'h3FF, 16'hFFFF}, 20, 32'h0, rx);
    send({6'd11, 10'h001, 16'h8001}, 33, 32'h0, rx);
    #200;
    chk("len_err_count", n_err_obs, n_err_exp);
    chk("len_fields", {bus.cmd_code, bus.cmd_addr, bus.cmd_data}, {6'd19, 10'h00B, 16'h0});

    // reset in the middle of a frame with cs_n still held low afterwards
    n_ack_exp++;
    bus.tx_word = 32'hFFFF_FFFF;
    bus.mosi = 1'b1;
    bus.cs_n = 1'b0;
    #100;
    for (int i = 0; i < 15; i++) begin
      bus.sck = 1'b0; #100;
      bus.sck = 1'b1; #100;
    end
    rst = 1'b1;
    #40;
    chk_zero_outputs("mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sck = 1'b0; #100;
      bus.sck = 1'b1; #100;
    end
    bus.cs_n = 1'b1;
    #300;
    chk("post_reset_err", n_err_obs, n_err_exp);
    chk("post_reset_ack", n_ack_obs, n_ack_exp);
    send({6'd8, 10'd4, 16'h0}, 32, 32'h0F0F_00FF, rx);
    #200;
    chk("unrst_code", {26'd0, bus.cmd_code}, 32'd8);
    chk("unrst_addr", {22'd0, bus.cmd_addr}, 32'd4);
    chk("unrst_miso", rx, 32'h0F0F_00FF);

    // back-to-back frames, 100 ns cs_n-high gap
    send({6'd24, 10'h155, 16'hBEEF}, 32, 32'hCAFE_0001, rx);
    chk("b2b_first_miso", rx, 32'hCAFE_0001);
    send({6'd23, 10'h2AA, 16'h4321}, 32, 32'h8000_0003, rx);
    #300;
    chk("b2b_second_miso", rx, 32'h8000_0003);
    chk("b2b_fields", {bus.cmd_code, bus.cmd_addr, bus.cmd_data}, {6'd23, 10'h2AA, 16'h4321});
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("final_ack_count", n_ack_obs, n_ack_exp);
    chk("final_err_count", n_err_obs, n_err_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Chip-side SPI responder for the probe command link. It sits between the external SPI pins and the command dispatcher in the `clk_50M` domain. It oversamples `sck`, `cs_n` and `mosi`, deserializes 32-bit LSB-first frames into code, address and data fields, and shifts a 32-bit response word out on `miso` in the same frame.

## Interface
Parameters:
- `LEN_SPI`, 32, frame length in bits.
- `SPI_CODE_LEN`, 6, command code width (frame bits [31:26]).
- `SPI_ADDR_LEN`, 10, address width (frame bits [25:16]).
- `SPI_DATA_LEN`, 16, data width (frame bits [15:0]).

Ports:
- `clk_50M`  in  1  system clock, 50 MHz. One clock only.
- `rst`  in  1  asynchronous, active-high reset.
- `sck`  in  1  SPI clock (asynchronous), idles high.
- `cs_n`  in  1  SPI chip select (asynchronous), active low.
- `mosi`  in  1  SPI data from master (asynchronous).
- `miso`  out  1  SPI data to master.
- `tx_word`  in  32  response word, captured at frame start.
- `tx_ack`  out  1  one-cycle pulse: `tx_word` has been captured.
- `cmd_valid`  out  1  one-cycle pulse: a complete non-NOP frame was received.
- `cmd_code`  out  6  frame bits [31:26]; held until the next `cmd_valid`.
- `cmd_addr`  out  10  frame bits [25:16]; held until the next `cmd_valid`.
- `cmd_data`  out  16  frame bits [15:0]; held until the next `cmd_valid`.
- `frame_err`  out  1  one-cycle pulse: frame ended with a bit count other than 32.

## Operation
- Input conditioning:
  - `sck`, `cs_n` and `mosi` each pass through a 2-FF synchronizer.
  - Edge detect compares sync stage 2 with a stage-3 register.
  - Detected events: `sck_fall`, `cs_fall`, `cs_rise`.
- Framing:
  - The master changes `mosi` at `sck` rising edges and samples `miso` at `sck` falling edges.
  - The slave therefore samples `mosi` and advances `miso` on `sck_fall` only. `sck` rising edges are ignored.
- FSM states:
  - IDLE:
    - Entered on reset.
    - On `cs_fall`: load shift_tx from `tx_word`, pulse `tx_ack`, clear bit_cnt, go to SHIFT.
  - SHIFT, on each `sck_fall` with `cs_n` low:
    - shift_rx <= {mosi_s, shift_rx[31:1]}, so bit 0 is received first.
    - shift_tx >>= 1.
    - bit_cnt increments, saturating at 33.
  - SHIFT, on `cs_rise`, go to DONE.
  - DONE, one cycle, then IDLE:
    - If bit_cnt == 32 and code != 0: latch the three fields and pulse `cmd_valid`.
    - If bit_cnt == 32 and code == 0: dummy/NOP frame. No pulse; fields unchanged.
    - If bit_cnt != 32: pulse `frame_err`; no `cmd_valid`; fields unchanged.
- `miso`:
  - Equals shift_tx[0] while in SHIFT.
  - Driven 0 otherwise; no tristate.
- `cs_fall` while in DONE is accepted on the next cycle. Back-to-back frames must work with a 100 ns gap between frames.
- Reset mid-frame:
  - All state clears and the FSM returns to IDLE.
  - The partial frame is discarded with no `frame_err`.
  - If `cs_n` is still low when reset releases, the slave waits for the next `cs_fall`.

## Timing
- Reset values: `miso` 0, `tx_ack` 0, `cmd_valid` 0, `frame_err` 0, `cmd_code`/`cmd_addr`/`cmd_data` 0, FSM in IDLE.
- Synchronizer-to-event latency is 2–3 `clk_50M` cycles.
- `tx_ack`: 3 cycles after `cs_n` falls at the pin (±1 for phase).
- First `miso` bit: valid no later than 4 cycles after `cs_n` falls. This is inside the 100 ns half-period before the first `sck` fall.
- Each `miso` update lands 3–4 cycles after an `sck` fall, which gives at least 5 cycles of stability before the next fall.
- `cmd_valid` / `frame_err`: 4 cycles after `cs_n` rises at the pin; each is exactly one cycle wide.
- Supported clocking: `sck` half-period ≥ 5 `clk_50M` cycles (100 ns nominal, 5 MHz).
- `cmd_valid` and `frame_err` are never asserted together.

## Structure
- Shared package `spi_pkg`:
  - Field widths and bit positions (code [31:26], address [25:16], data [15:0]).
  - Command code constants: CMD_NOP=0, CMD_WR_REC=4, CMD_AFE_RST=7, CMD_AFE_UNRST=8, CMD_WR_ELEC=10, CMD_RD_ELEC=11, CMD_RD_ADC=19, CMD_WR_CHEM=20, CMD_RD_CHEM=21.
  - FSM state typedef.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall detect. Instantiated three times, once each for `sck`, `cs_n` and `mosi`.

## Test plan
- Frame {6'd4, 10'h008, 16'h001D}, LSB first, 5 MHz → one `cmd_valid`; `cmd_code`=4, `cmd_addr`=0x008, `cmd_data`=0x001D.
- `tx_word`=0xA5A5_3C01 during a `{6'd19, 10'h00B, 16'h0}` frame → master collects 0xA5A5_3C01 on `miso`; `tx_ack` fires once; `cmd_code`=19, `cmd_addr`=0x00B.
- All-zero dummy frame → no `cmd_valid`, no `frame_err`; the previous fields are unchanged.
- `cs_n` raised after 20 bits, then a separate 33-bit frame → two `frame_err` pulses, no `cmd_valid`.
- `rst` pulsed at bit 15, then a full `{6'd8, 10'd4, 16'h0}` frame → all outputs 0 during reset; only the second frame decodes (`cmd_code`=8, `cmd_addr`=4).
- Frames sent back to back with a 100 ns `cs_n`-high gap (codes 24, 23) → two `cmd_valid` pulses in order, with correct fields each time.
